// File: rtl/traffic_gen_mc_engine.sv
// rtl/traffic_gen_mc_engine.sv - multi-channel pattern write/read traffic generator engine
module traffic_gen_mc_engine #(
  parameter int          N_CH       = 2,
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] POLY       = 32'h04C11DB7
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         start_i,
  input  logic [1:0]                   mode_i,
  input  logic [CNT_WIDTH-1:0]         len_i,
  input  logic [DATA_WIDTH-1:0]        seed_i,
  input  logic [N_CH-1:0]              ch_en_i,
  output logic [N_CH-1:0]              w_valid_o,
  output logic [N_CH*DATA_WIDTH-1:0]   w_data_o,
  input  logic [N_CH-1:0]              w_ready_i,
  input  logic [N_CH-1:0]              r_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0]   r_data_i,
  output logic [N_CH-1:0]              r_ready_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o,
  output logic [DATA_WIDTH-1:0]        cks_o
);

  // Four spare bits let up to N_CH mismatches per cycle add before saturating.
  localparam int                    ERR_W   = CNT_WIDTH + 4;
  localparam logic [ERR_W-1:0]      ERR_MAX = ERR_W'({CNT_WIDTH{1'b1}});
  localparam logic [DATA_WIDTH-1:0] POLY_W  = DATA_WIDTH'(POLY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [N_CH-1:0]       ch_en_q, ch_en_d;
  logic [CNT_WIDTH-1:0]  wcnt_q [N_CH];
  logic [CNT_WIDTH-1:0]  wcnt_d [N_CH];
  logic [CNT_WIDTH-1:0]  rcnt_q [N_CH];
  logic [CNT_WIDTH-1:0]  rcnt_d [N_CH];
  logic [DATA_WIDTH-1:0] wgen_q [N_CH];
  logic [DATA_WIDTH-1:0] wgen_d [N_CH];
  logic [DATA_WIDTH-1:0] rgen_q [N_CH];
  logic [DATA_WIDTH-1:0] rgen_d [N_CH];
  logic [CNT_WIDTH-1:0]  err_q, err_d;
  logic [DATA_WIDTH-1:0] cks_q, cks_d;
  logic [ERR_W-1:0]      err_sum;
  logic [N_CH-1:0]       w_valid, r_ready;
  logic                  done_cond;

  function automatic logic [DATA_WIDTH-1:0] gen_next(input logic [1:0] mode,
                                                     input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    case (mode)
      2'd0:    r = v + DATA_WIDTH'(1);
      2'd1:    r = {v[DATA_WIDTH-2:0], 1'b0} ^ (v[DATA_WIDTH-1] ? POLY_W : '0);
      default: r = v;
    endcase
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; clear wins over everything, including start
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_RUN;
        S_RUN:   if (done_cond) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs; valid/ready come only from registered state so no input reaches an output
  always_comb begin
    busy_o    = (state_q == S_RUN);
    done_o    = (state_q == S_DONE);
    err_cnt_o = err_q;
    cks_o     = cks_q;
    w_valid   = '0;
    r_ready   = '0;
    w_data_o  = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_valid[c] = (state_q == S_RUN) && ch_en_q[c] && (wcnt_q[c] < len_q);
      r_ready[c] = (state_q == S_RUN) && ch_en_q[c] && (rcnt_q[c] < len_q);
      w_data_o[c*DATA_WIDTH +: DATA_WIDTH] = wgen_q[c];
    end
    w_valid_o = w_valid;
    r_ready_o = r_ready;
  end

  // Datapath next state: config latch on start, per-channel handshakes, checker and done test
  always_comb begin
    mode_d  = mode_q;
    len_d   = len_q;
    ch_en_d = ch_en_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wgen_d  = wgen_q;
    rgen_d  = rgen_q;
    cks_d   = cks_q;
    err_d   = err_q;
    err_sum = ERR_W'(err_q);
    if (clear_i) begin
      for (int c = 0; c < N_CH; c++) begin
        wcnt_d[c] = '0;
        rcnt_d[c] = '0;
        wgen_d[c] = '0;
        rgen_d[c] = '0;
      end
      cks_d = '0;
      err_d = '0;
    end else if (state_q == S_IDLE && start_i) begin
      mode_d  = mode_i;
      len_d   = len_i;
      ch_en_d = ch_en_i;
      for (int c = 0; c < N_CH; c++) begin
        wcnt_d[c] = '0;
        rcnt_d[c] = '0;
        wgen_d[c] = seed_i + DATA_WIDTH'(c);
        rgen_d[c] = seed_i + DATA_WIDTH'(c);
      end
      cks_d = '0;
      err_d = '0;
    end else if (state_q == S_RUN) begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_valid[c] && w_ready_i[c]) begin
          wcnt_d[c] = wcnt_q[c] + CNT_WIDTH'(1);
          wgen_d[c] = gen_next(mode_q, wgen_q[c]);
        end
        if (r_ready[c] && r_valid_i[c]) begin
          rcnt_d[c] = rcnt_q[c] + CNT_WIDTH'(1);
          cks_d     = cks_d ^ r_data_i[c*DATA_WIDTH +: DATA_WIDTH];
          if (r_data_i[c*DATA_WIDTH +: DATA_WIDTH] != rgen_q[c]) err_sum = err_sum + ERR_W'(1);
          rgen_d[c] = gen_next(mode_q, rgen_q[c]);
        end
      end
      err_d = (err_sum > ERR_MAX) ? {CNT_WIDTH{1'b1}} : err_sum[CNT_WIDTH-1:0];
    end
    // Uses this cycle's post-handshake counts so DONE follows the last handshake directly
    done_cond = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_en_q[c] && (wcnt_d[c] != len_q || rcnt_d[c] != len_q)) done_cond = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= '0;
      len_q   <= '0;
      ch_en_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        wcnt_q[c] <= '0;
        rcnt_q[c] <= '0;
        wgen_q[c] <= '0;
        rgen_q[c] <= '0;
      end
      cks_q <= '0;
      err_q <= '0;
    end else begin
      mode_q  <= mode_d;
      len_q   <= len_d;
      ch_en_q <= ch_en_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wgen_q  <= wgen_d;
      rgen_q  <= rgen_d;
      cks_q   <= cks_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_traffic_gen_mc_engine.sv
// tb/tb_traffic_gen_mc_engine.sv - scoreboard bench for traffic_gen_mc_engine
module tb_traffic_gen_mc_engine;
  localparam int          NC   = 2;
  localparam int          DW   = 32;
  localparam int          CW   = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] CORR = 32'hDEAD0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           clear_i = 1'b0, start_i = 1'b0;
  logic [1:0]     mode_i = '0;
  logic [CW-1:0]  len_i = '0;
  logic [DW-1:0]  seed_i = '0;
  logic [NC-1:0]  ch_en_i = '0;
  logic [NC-1:0]  w_valid_o, r_ready_o;
  logic [NC-1:0]  w_ready_i = '0, r_valid_i = '0;
  logic [NC*DW-1:0] w_data_o;
  logic [NC*DW-1:0] r_data_i = '0;
  logic           busy_o, done_o;
  logic [CW-1:0]  err_cnt_o;
  logic [DW-1:0]  cks_o;

  logic [NC-1:0]    s_w_valid, s_r_ready;
  logic [NC*DW-1:0] s_w_data;
  logic             s_busy, s_done;
  logic [2:0]       s_err;
  logic [DW-1:0]    s_cks;

  traffic_gen_mc_engine #(.N_CH(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .POLY(POLY)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
    .len_i(len_i), .seed_i(seed_i), .ch_en_i(ch_en_i), .w_valid_o(w_valid_o), .w_data_o(w_data_o),
    .w_ready_i(w_ready_i), .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_ready_o(r_ready_o),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .cks_o(cks_o));

  // Narrow error counter copy, fed identical stimulus, to reach saturation quickly
  traffic_gen_mc_engine #(.N_CH(NC), .DATA_WIDTH(DW), .CNT_WIDTH(3), .POLY(POLY)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i), .mode_i(mode_i),
    .len_i(len_i[2:0]), .seed_i(seed_i), .ch_en_i(ch_en_i), .w_valid_o(s_w_valid), .w_data_o(s_w_data),
    .w_ready_i(w_ready_i), .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_ready_o(s_r_ready),
    .busy_o(s_busy), .done_o(s_done), .err_cnt_o(s_err), .cks_o(s_cks));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] model_next(input logic [1:0] m, input logic [DW-1:0] v);
    if (m == 2'd0) return v + 1;
    if (m == 2'd1) return {v[DW-2:0], 1'b0} ^ (v[DW-1] ? POLY : 32'h0);
    return v;
  endfunction

  logic [DW-1:0] exp_q [NC][$];
  logic [DW-1:0] lb_q  [NC][$];
  int            rd_idx [NC];

  function automatic bit is_corrupt(input int mode, input int idx);
    if (mode == 1) return (idx == 1 || idx == 3);
    return (mode == 2);
  endfunction

  task automatic drive_inputs(input bit bp, input int corrupt);
    for (int c = 0; c < NC; c++) begin
      w_ready_i[c] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (lb_q[c].size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
        r_valid_i[c] = 1'b1;
        r_data_i[c*DW +: DW] = lb_q[c][0] ^ (is_corrupt(corrupt, rd_idx[c]) ? CORR : 32'h0);
      end else begin
        r_valid_i[c] = 1'b0;
        r_data_i[c*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic run_phase(input string nm, input logic [1:0] mode, input int len,
                           input logic [DW-1:0] seed, input logic [NC-1:0] en, input bit bp,
                           input int corrupt, input int exp_done, input int abort_at);
    int            n, exp_err, dis_act, done_cnt;
    logic [DW-1:0] exp_cks, d, v;
    logic [NC-1:0] prev_stall;
    logic [DW-1:0] prev_data [NC];
    bit            finished;
    exp_err = 0; exp_cks = '0; dis_act = 0; prev_stall = '0; finished = 0;
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete(); lb_q[c].delete(); rd_idx[c] = 0; prev_data[c] = '0;
      v = seed + DW'(c);
      if (en[c]) for (int i = 0; i < len; i++) begin
        exp_q[c].push_back(v); lb_q[c].push_back(v); v = model_next(mode, v);
      end
    end
    @(posedge clk); #1;
    mode_i = mode; len_i = CW'(len); seed_i = seed; ch_en_i = en; start_i = 1'b1;
    w_ready_i = '0; r_valid_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0; mode_i = ~mode; seed_i = ~seed; ch_en_i = ~en; len_i = '0;
    n = 1;
    drive_inputs(bp, corrupt);
    while (!finished) begin
      @(negedge clk);
      if (n == 1) begin
        check_eq({nm, "_busy1"}, busy_o, 1'b1);
        check_eq({nm, "_valid1"}, w_valid_o, (len > 0) ? en : '0);
      end
      if (done_o) begin
        if (exp_done != 0) check_eq({nm, "_done_lat"}, n, exp_done);
        check_eq({nm, "_busy_done"}, busy_o, 1'b0);
        check_eq({nm, "_err"}, err_cnt_o, (exp_err > 16'hFFFF) ? 16'hFFFF : exp_err);
        check_eq({nm, "_err_small"}, s_err, (exp_err > 7) ? 7 : exp_err);
        check_eq({nm, "_cks"}, cks_o, exp_cks);
        for (int c = 0; c < NC; c++) begin
          check_eq({nm, "_wr_left"}, exp_q[c].size(), 0);
          check_eq({nm, "_rd_left"}, lb_q[c].size(), 0);
        end
        check_eq({nm, "_dis_act"}, dis_act, 0);
        @(negedge clk);
        check_eq({nm, "_done_1cyc"}, {busy_o, done_o}, 2'b00);
        check_eq({nm, "_cks_hold"}, cks_o, exp_cks);
        finished = 1;
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (!en[c] && (w_valid_o[c] || r_ready_o[c])) dis_act++;
          if (prev_stall[c]) begin
            check_eq({nm, "_hold_v"}, w_valid_o[c], 1'b1);
            check_eq({nm, "_hold_d"}, w_data_o[c*DW +: DW], prev_data[c]);
          end
          if (w_valid_o[c] && w_ready_i[c]) begin
            if (exp_q[c].size() == 0) check_eq({nm, "_extra_wr"}, 1, 0);
            else check_eq({nm, "_wdata"}, w_data_o[c*DW +: DW], exp_q[c].pop_front());
          end
          if (r_valid_i[c] && r_ready_o[c]) begin
            d = r_data_i[c*DW +: DW];
            exp_cks = exp_cks ^ d;
            if (lb_q[c].size() == 0 || d !== lb_q[c][0]) exp_err++;
            if (lb_q[c].size() > 0) void'(lb_q[c].pop_front());
            rd_idx[c]++;
          end
          prev_stall[c] = w_valid_o[c] && !w_ready_i[c];
          prev_data[c]  = w_data_o[c*DW +: DW];
        end
        @(posedge clk); #1;
        n++;
        if (abort_at != 0 && n == abort_at) begin
          clear_i = 1'b1; start_i = 1'b1; w_ready_i = '0; r_valid_i = '0;
          @(posedge clk); #1;
          clear_i = 1'b0; start_i = 1'b0;
          @(negedge clk);
          check_eq({nm, "_clr_state"}, {busy_o, done_o}, 2'b00);
          check_eq({nm, "_clr_err"}, err_cnt_o, 0);
          check_eq({nm, "_clr_cks"}, cks_o, 0);
          check_eq({nm, "_clr_vr"}, {w_valid_o, r_ready_o}, '0);
          done_cnt = 0;
          repeat (6) begin @(negedge clk); if (done_o || busy_o) done_cnt++; end
          check_eq({nm, "_clr_nodone"}, done_cnt, 0);
          finished = 1;
        end else if (n > 200) begin
          check_eq({nm, "_timeout"}, 0, 1);
          finished = 1;
        end else begin
          drive_inputs(bp, corrupt);
        end
      end
    end
    w_ready_i = '0; r_valid_i = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_state", {busy_o, done_o}, 2'b00);
    check_eq("rst_err", err_cnt_o, 0);
    check_eq("rst_cks", cks_o, 0);
    check_eq("rst_vr", {w_valid_o, r_ready_o}, '0);
    check_eq("rst_wdata", w_data_o[31:0] | w_data_o[63:32], 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_phase("incr",    2'd0, 4, 32'h10,       2'b11, 0, 0, 5, 0);
    check_eq("incr_cks_const", cks_o, 32'h4);
    run_phase("lfsr",    2'd1, 3, 32'h1,        2'b01, 0, 0, 4, 0);
    check_eq("lfsr_cks_const", cks_o, 32'h7);
    run_phase("bp_incr", 2'd0, 7, 32'hFFFFFFFE, 2'b11, 1, 0, 0, 0);
    run_phase("bp_lfsr", 2'd1, 7, 32'h0,        2'b11, 1, 0, 0, 0);
    run_phase("bp_lfsr2",2'd1, 7, 32'h80000001, 2'b10, 1, 0, 0, 0);
    run_phase("bp_const",2'd2, 5, 32'hA5A5,     2'b11, 1, 0, 0, 0);
    run_phase("corr2",   2'd0, 5, 32'h100,      2'b11, 0, 1, 6, 0);
    check_eq("corr2_err_const", err_cnt_o, 16'd4);
    run_phase("corr_sat",2'd1, 5, 32'h3,        2'b11, 1, 2, 0, 0);
    check_eq("sat_small_const", s_err, 3'd7);
    check_eq("sat_main_const", err_cnt_o, 16'd10);
    run_phase("len0",    2'd0, 0, 32'h55,       2'b11, 0, 0, 2, 0);
    run_phase("en0",     2'd0, 4, 32'h55,       2'b00, 0, 0, 2, 0);
    run_phase("abort",   2'd0, 7, 32'h200,      2'b11, 1, 0, 0, 3);
    run_phase("after",   2'd0, 4, 32'h10,       2'b11, 0, 0, 5, 0);
    check_eq("after_cks_const", cks_o, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
